// File: rtl/lift_row_seq.sv
// lift_row_seq -- sequencer for one row of the 5/3 lifting transform.
//
// Walks a row of N samples held in an external single-port RAM. For each
// step it fetches left/centre/right, presents them to the lifting datapath,
// waits LIFT_LAT clocks, and writes res_s back over the centre sample.
//   forward: predict pass (odd indices), then update pass (even indices)
//   inverse: update pass (even indices), then predict pass (odd indices)
// Row edges use symmetric extension: i = 0 uses 1 for left,
// and i = N-1 uses N-2 for right.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, fwd         begin a row (ignored while busy); direction, sampled at start
//   busy, done         row in progress; 1-cycle pulse after the last write
//   mem_addr, mem_we   RAM address (read or write) and write enable
//   mem_wr_data        RAM write data (res_s while writing, else 0)
//   mem_rd_data        RAM read data, valid 1 clk after mem_addr
//   l_s, s_s, r_s      datapath operands, stable from LIFT through WR
//   e_o_s, f_i_s       1 = predict step / 1 = forward direction
//   res_s              datapath result, valid LIFT_LAT clks after the operands
//   abort              only with LIFT_ABORT_EN defined: drop the row at once
//
// Build option: define LIFT_ABORT_EN to add the abort input.
module lift_row_seq #(
  parameter int W        = 16,
  parameter int N        = 8,
  parameter int AW       = 3,
  parameter int LIFT_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          fwd,
`ifdef LIFT_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rd_data,
  output logic          mem_we,
  output logic [W-1:0]  mem_wr_data,
  output logic [W-1:0]  l_s,
  output logic [W-1:0]  s_s,
  output logic [W-1:0]  r_s,
  output logic          e_o_s,
  output logic          f_i_s,
  input  logic [W-1:0]  res_s
);

  localparam int CW = (LIFT_LAT > 1) ? $clog2(LIFT_LAT) : 1;
  localparam logic [AW-1:0] LAST_ODD  = AW'(N - 1);
  localparam logic [AW-1:0] LAST_EVEN = AW'(N - 2);

  typedef enum logic [3:0] {
    IDLE, RD_L, RD_S, RD_R, CAPT, LIFT, WR, PASS2, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic          pass2;
  logic [CW-1:0] lat_cnt;
  logic [W-1:0]  l_cap;
  logic [W-1:0]  s_cap;
  logic          we_reg;
  logic          abort_hit;

  logic [AW-1:0] last_idx;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] start_idx;
  logic [AW-1:0] pass2_idx;

  // Mirrored neighbours: only i = 0 and i = N-1 fall off the row.
  function automatic logic [AW-1:0] left_of(input logic [AW-1:0] i);
    return (i == '0) ? AW'(1) : i - AW'(1);
  endfunction

  function automatic logic [AW-1:0] right_of(input logic [AW-1:0] i);
    return (i == LAST_ODD) ? LAST_EVEN : i + AW'(1);
  endfunction

`ifdef LIFT_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign last_idx  = e_o_s ? LAST_ODD : LAST_EVEN;
  assign next_idx  = idx + AW'(2);
  assign start_idx = fwd ? AW'(1) : '0;    // forward begins with odd (predict)
  assign pass2_idx = e_o_s ? '0 : AW'(1);  // other parity from the current one

  // The write enable is gated by abort so that an abort landing in WR
  // suppresses the write at the same edge it would have happened.
  assign mem_we      = we_reg & ~abort_hit;
  assign mem_wr_data = mem_we ? res_s : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pass2    <= 1'b0;
      lat_cnt  <= '0;
      l_cap    <= '0;
      s_cap    <= '0;
      we_reg   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      l_s      <= '0;
      s_s      <= '0;
      r_s      <= '0;
      e_o_s    <= 1'b0;
      f_i_s    <= 1'b0;
    end else if (abort_hit && state != IDLE) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      we_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD_L;
            busy     <= 1'b1;
            pass2    <= 1'b0;
            f_i_s    <= fwd;
            e_o_s    <= fwd;
            idx      <= start_idx;
            mem_addr <= left_of(start_idx);
          end
        end
        RD_L: begin
          state    <= RD_S;
          mem_addr <= idx;
        end
        RD_S: begin
          state    <= RD_R;
          l_cap    <= mem_rd_data;
          mem_addr <= right_of(idx);
        end
        RD_R: begin
          state <= CAPT;
          s_cap <= mem_rd_data;
        end
        CAPT: begin
          // Operands are launched together so they stay stable through WR.
          state   <= LIFT;
          l_s     <= l_cap;
          s_s     <= s_cap;
          r_s     <= mem_rd_data;
          lat_cnt <= '0;
        end
        LIFT: begin
          if (lat_cnt == CW'(LIFT_LAT - 1)) begin
            state    <= WR;
            we_reg   <= 1'b1;
            mem_addr <= idx;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        WR: begin
          we_reg <= 1'b0;
          if (idx == last_idx) begin
            if (pass2) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= PASS2;
            end
          end else begin
            state    <= RD_L;
            idx      <= next_idx;
            mem_addr <= left_of(next_idx);
          end
        end
        PASS2: begin
          state    <= RD_L;
          pass2    <= 1'b1;
          e_o_s    <= ~e_o_s;
          idx      <= pass2_idx;
          mem_addr <= left_of(pass2_idx);
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
